// File: rtl/ctrl_pkg.sv
// Shared control-path types: opcode constants, ALUOp classes and the per-stage control bundles.
package ctrl_pkg;

  localparam int unsigned OPC_BITS   = 6;
  localparam int unsigned ALUOP_BITS = 2;

  localparam logic [OPC_BITS-1:0] R_FORMAT = 6'd0;
  localparam logic [OPC_BITS-1:0] MADDU    = 6'd28;
  localparam logic [OPC_BITS-1:0] ADDIU    = 6'd9;
  localparam logic [OPC_BITS-1:0] LW       = 6'd35;
  localparam logic [OPC_BITS-1:0] SW       = 6'd43;
  localparam logic [OPC_BITS-1:0] BEQ      = 6'd4;
  localparam logic [OPC_BITS-1:0] J        = 6'd2;

  localparam logic [ALUOP_BITS-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_BITS-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_BITS-1:0] ALUOP_FUNCT = 2'b10;

  // Full decode result as loaded into ID/EX; multi marks a multi-cycle EX op.
  typedef struct packed {
    logic                  valid;
    logic                  regdst;
    logic                  alusrc;
    logic                  extsel;
    logic                  memread;
    logic                  memwrite;
    logic                  branch;
    logic                  jump;
    logic                  regwrite;
    logic                  memtoreg;
    logic                  multi;
    logic [ALUOP_BITS-1:0] aluop;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '0;

  typedef struct packed {
    logic memread;
    logic memwrite;
    logic branch;
    logic jump;
    logic regwrite;
    logic memtoreg;
  } mem_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-control-bundle decoder; unknown opcodes and invalid slots give CTRL_NOP.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 6
) (
  input  logic             valid,
  input  logic [OPC_W-1:0] opcode,
  output ctrl_bundle_t     ctrl_c
);

  always_comb begin
    ctrl_c = CTRL_NOP;
    case (opcode)
      OPC_W'(R_FORMAT): begin
        ctrl_c.valid    = 1'b1;
        ctrl_c.regdst   = 1'b1;
        ctrl_c.regwrite = 1'b1;
        ctrl_c.aluop    = ALUOP_FUNCT;
      end
      OPC_W'(MADDU): begin
        ctrl_c.valid    = 1'b1;
        ctrl_c.regdst   = 1'b1;
        ctrl_c.regwrite = 1'b1;
        ctrl_c.multi    = 1'b1;
        ctrl_c.aluop    = ALUOP_FUNCT;
      end
      OPC_W'(ADDIU): begin
        ctrl_c.valid    = 1'b1;
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.regwrite = 1'b1;
        ctrl_c.aluop    = ALUOP_ADD;
      end
      OPC_W'(LW): begin
        ctrl_c.valid    = 1'b1;
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.memtoreg = 1'b1;
        ctrl_c.regwrite = 1'b1;
        ctrl_c.memread  = 1'b1;
        ctrl_c.extsel   = 1'b1;
        ctrl_c.aluop    = ALUOP_ADD;
      end
      OPC_W'(SW): begin
        ctrl_c.valid    = 1'b1;
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.memwrite = 1'b1;
        ctrl_c.extsel   = 1'b1;
        ctrl_c.aluop    = ALUOP_ADD;
      end
      OPC_W'(BEQ): begin
        ctrl_c.valid    = 1'b1;
        ctrl_c.branch   = 1'b1;
        ctrl_c.extsel   = 1'b1;
        ctrl_c.aluop    = ALUOP_SUB;
      end
      OPC_W'(J): begin
        ctrl_c.valid    = 1'b1;
        ctrl_c.jump     = 1'b1;
      end
      default: ctrl_c = CTRL_NOP;
    endcase
    if (!valid) ctrl_c = CTRL_NOP;
  end

endmodule

// File: rtl/control_pipe_stages.sv
// ID/EX, EX/MEM, MEM/WB control registers with hold, bubble, flush and multi-cycle MADDU occupancy.
// Optional sticky illegal-opcode flag enabled by defining CTRL_ILLEGAL_TRAP_EN.
module control_pipe_stages
  import ctrl_pkg::*;
#(
  parameter int unsigned OPC_W        = 6,
  parameter int unsigned ALUOP_W      = 2,
  parameter int unsigned MADDU_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               id_valid,
  input  logic [OPC_W-1:0]   id_opcode,
  input  logic               bubble,
  input  logic               flush,
  output logic               ex_valid,
  output logic               ex_regdst,
  output logic               ex_alusrc,
  output logic               ex_extsel,
  output logic               ex_memread,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               mem_memread,
  output logic               mem_memwrite,
  output logic               mem_branch,
  output logic               mem_jump,
  output logic               wb_regwrite,
  output logic               wb_memtoreg,
  output logic               busy_stall,
  output logic               illegal_op
);

  localparam int unsigned CNT_W = (MADDU_CYCLES > 1) ? $clog2(MADDU_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MADDU_CYCLES - 1);

  ctrl_bundle_t     id_ctrl_c;
  ctrl_bundle_t     ex_q, ex_d;
  mem_ctrl_t        mem_q, mem_d;
  wb_ctrl_t         wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .valid  (id_valid),
    .opcode (id_opcode),
    .ctrl_c (id_ctrl_c)
  );

  // Stage advance: hold > MADDU occupancy > bubble/flush > normal.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (hold) begin
      cnt_d = cnt_q;
    end else if (cnt_q != '0) begin
      wb_d.regwrite = mem_q.regwrite;
      wb_d.memtoreg = mem_q.memtoreg;
      mem_d         = '0;
      cnt_d         = cnt_q - CNT_W'(1);
    end else begin
      wb_d.regwrite  = mem_q.regwrite;
      wb_d.memtoreg  = mem_q.memtoreg;
      mem_d.memread  = ex_q.memread;
      mem_d.memwrite = ex_q.memwrite;
      mem_d.branch   = ex_q.branch;
      mem_d.jump     = ex_q.jump;
      mem_d.regwrite = ex_q.regwrite;
      mem_d.memtoreg = ex_q.memtoreg;
      ex_d           = (flush || bubble) ? CTRL_NOP : id_ctrl_c;
      cnt_d          = ex_d.multi ? CNT_LOAD : '0;
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q   <= CTRL_NOP;
      mem_q  <= '0;
      wb_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // With id_valid=1 the decoder leaves valid clear only for an unlisted opcode.
  always_comb begin
    illegal_d = illegal_q;
    if (id_valid && !id_ctrl_c.valid && !flush && !hold && !busy_q) illegal_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  assign ex_valid     = ex_q.valid;
  assign ex_regdst    = ex_q.regdst;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_extsel    = ex_q.extsel;
  assign ex_memread   = ex_q.memread;
  assign ex_aluop     = ALUOP_W'(ex_q.aluop);
  assign mem_memread  = mem_q.memread;
  assign mem_memwrite = mem_q.memwrite;
  assign mem_branch   = mem_q.branch;
  assign mem_jump     = mem_q.jump;
  assign wb_regwrite  = wb_q.regwrite;
  assign wb_memtoreg  = wb_q.memtoreg;
  assign busy_stall   = busy_q;

endmodule

// File: doc/control_pipe_stages.md
Name: control_pipe_stages

Overview:
- Parametrised successor to the single-stage pipelined control decoder.
- Decodes the ID-stage opcode into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Supports global hold, bubble insertion for load-use, flush on taken branch/jump, and multi-cycle MADDU occupancy of EX.
- Sits beside the datapath pipeline registers; the hazard unit drives bubble/flush.

Parameters:
OPC_W, 6, opcode width
ALUOP_W, 2, ALUOp width; encodings 00 add, 01 sub, 10 funct-decoded, zero-extended to ALUOP_W
MADDU_CYCLES, 2, EX occupancy of MADDU in cycles (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
hold  in  1  freeze all control stage registers
id_valid  in  1  ID slot holds a real instruction
id_opcode  in  OPC_W  ID-stage opcode
bubble  in  1  load-use: insert NOP into EX, ID held upstream
flush  in  1  kill ID instruction (taken branch/jump)
ex_valid, ex_regdst, ex_alusrc, ex_extsel, ex_memread  out  1 each  EX-stage controls
ex_aluop  out  ALUOP_W  EX ALU operation class
mem_memread, mem_memwrite, mem_branch, mem_jump  out  1 each  MEM-stage controls
wb_regwrite, wb_memtoreg  out  1 each  WB-stage controls
busy_stall  out  1  MADDU occupying EX; front end must hold IF/ID
illegal_op  out  1  see Optional Feature

Behaviour:
- All stage registers and outputs are 0 on rst, asynchronously. A reset mid-MADDU clears the counter and busy_stall at once.
- Decode is combinational, one per opcode; unlisted bits are 0:
  - R(0): regdst, regwrite, aluop 10.
  - MADDU(28): same as R, plus multi-cycle.
  - ADDIU(9): alusrc, regwrite, aluop 00.
  - LW(35): alusrc, memtoreg, regwrite, memread, extsel, aluop 00.
  - SW(43): alusrc, memwrite, extsel, aluop 00.
  - BEQ(4): branch, extsel, aluop 01.
  - J(2): jump only.
- Unknown opcode decodes to an all-zero bundle, never X.
- id_valid=0 forces the all-zero bundle.
- Latency: an instruction decoded in cycle N appears on ex_* at N+1, mem_* at N+2, wb_* at N+3.
- Per-edge priority (highest first):
  1. hold=1: every stage register keeps its value; the MADDU counter is frozen.
  2. busy (counter != 0): EX holds, MEM loads a zero bundle, WB advances, counter decrements. flush/bubble are ignored; the front end is held by busy_stall.
  3. flush or bubble: EX loads a zero bundle; MEM and WB advance.
  4. Normal: all stages advance.
- MADDU: when MADDU is loaded into EX, the counter loads MADDU_CYCLES-1. busy_stall = (counter != 0), registered. With MADDU_CYCLES=1 it behaves as an R-type.
- MADDU leaves EX on the edge where the counter is 0.
- flush and bubble both high: treated as one bubble.

Optional Feature:
Macro CTRL_ILLEGAL_TRAP_EN.
- Defined: illegal_op is a sticky register. It sets at the edge where id_valid=1 with an unlisted opcode and is not flushed, held or busy. It is cleared only by rst. The offending instruction still enters EX as a NOP.
- Undefined: illegal_op is tied 0 and there is no extra flop.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants (R_FORMAT, MADDU, ADDIU, LW, SW, BEQ, J);
  - ALUOp encodings;
  - packed typedef ctrl_bundle_t with a CTRL_NOP zero constant.
- Sub-module ctrl_decode: the combinational opcode-to-ctrl_bundle_t decoder, reusable by the hazard unit.

Test Plan:
- LW at cycle 0, id_valid=1 -> ex_memread=1 and ex_alusrc=1 at cycle 1; mem_memread=1 at 2; wb_regwrite=1 and wb_memtoreg=1 at 3.
- SW then hold=1 for 3 cycles -> mem_memwrite stays 1 throughout; resumes advancing once hold drops.
- BEQ in ID with flush=1 -> ex_* all 0 next cycle; the prior ADDIU still reaches wb_regwrite=1.
- MADDU with MADDU_CYCLES=3 -> busy_stall=1 for 2 cycles; ex_aluop=10 for 3 cycles; mem_* 0 for 2 cycles; then wb_regwrite=1.
- rst pulsed asynchronously mid-MADDU (counter=1) -> busy_stall and all outputs 0 immediately, before the next clk edge.
- Opcode 6'd63 with CTRL_ILLEGAL_TRAP_EN -> illegal_op=1, sticky until rst; without the macro -> illegal_op=0. ex_* 0 in both builds.
